// File: rtl/sysarray_example_axis_gen_if.sv
// AXI4-Stream bundle between the packet generator and its consumer.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. Once tvalid is raised the master holds tvalid, tdata, tkeep
// and tlast unchanged until that transfer happens. tvalid never depends
// combinationally on tready.
//   tvalid  master -> slave  beat valid
//   tready  slave -> master  consumer ready
//   tdata   master -> slave  beat payload, DATA_WIDTH bits
//   tkeep   master -> slave  byte enables, DATA_WIDTH/8 bits
//   tlast   master -> slave  final beat of the packet
interface sysarray_example_axis_gen_if #(
    parameter int DATA_WIDTH = 512
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tkeep;
    logic                      tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/sysarray_example_axis_gen.sv
// AXI4-Stream packet generator. A start pulse in IDLE latches a byte length
// and a seed. The block then emits ceil(length/BPB) beats. Lane i of beat k
// carries seed + k*LANES + i, wrapping modulo 2^C_ADDER_BIT_WIDTH. When the
// final beat handshakes, the block spends one cycle in DONE with ctrl_done
// high, then returns to IDLE.
// Ports:
//   m_axis_aclk    clock, rising edge
//   m_axis_areset  asynchronous active-high reset
//   ctrl_start     start request, sampled only in IDLE
//   ctrl_length    packet length in bytes, latched on accepted start
//   ctrl_seed      pattern seed, latched on accepted start
//   ctrl_busy      high whenever the state is not IDLE
//   ctrl_done      one-cycle completion pulse (the DONE state)
//   dbg_state      current FSM state: 0 IDLE, 1 RUN, 2 DONE
//   m_axis         stream master port
module sysarray_example_axis_gen #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_LENGTH_WIDTH     = 32
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_areset,
    input  logic                          ctrl_start,
    input  logic [C_LENGTH_WIDTH-1:0]     ctrl_length,
    input  logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_seed,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,
    output logic [1:0]                    dbg_state,
    sysarray_example_axis_gen_if.master   m_axis
);
    localparam int BPB      = C_AXIS_TDATA_WIDTH / 8;
    localparam int LANES    = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
    localparam int LOG2_BPB = $clog2(BPB);
    localparam logic [C_ADDER_BIT_WIDTH-1:0] LANE_STEP = C_ADDER_BIT_WIDTH'(LANES);
    localparam logic [C_LENGTH_WIDTH-1:0]    ONE_BEAT  = C_LENGTH_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic                          tvalid_q;
    logic                          tlast_q;
    logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic [BPB-1:0]                tkeep_q;
    logic [C_ADDER_BIT_WIDTH-1:0]  base_q;       // first-lane value of the next beat to load
    logic [C_LENGTH_WIDTH-1:0]     beat_cnt;     // index of the next beat to load
    logic [C_LENGTH_WIDTH-1:0]     beats_q;      // total beats in the packet
    logic [BPB-1:0]                last_keep_q;  // tkeep for the final beat

    logic                          beat_hs;
    logic                          load_first;
    logic                          load_next;
    logic                          next_is_last;
    logic [C_LENGTH_WIDTH-1:0]     beats_in;
    logic [BPB-1:0]                keep_in;

    // The shift plus a remainder flag computes ceil(length/BPB) without
    // overflow, even when length is at its maximum value.
    assign beats_in = (ctrl_length >> LOG2_BPB)
                    + {{(C_LENGTH_WIDTH-1){1'b0}}, |ctrl_length[LOG2_BPB-1:0]};

    always_comb begin
        keep_in = '0;
        for (int j = 0; j < BPB; j++) begin
            keep_in[j] = (ctrl_length[LOG2_BPB-1:0] == '0)
                      || (LOG2_BPB'(j) < ctrl_length[LOG2_BPB-1:0]);
        end
    end

    function automatic logic [C_AXIS_TDATA_WIDTH-1:0] lane_pattern(
        input logic [C_ADDER_BIT_WIDTH-1:0] base
    );
        logic [C_AXIS_TDATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) begin
            d[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] = base + C_ADDER_BIT_WIDTH'(i);
        end
        return d;
    endfunction

    assign beat_hs      = tvalid_q && m_axis.tready;
    assign load_first   = (state == S_IDLE) && ctrl_start && (ctrl_length != '0);
    assign load_next    = (state == S_RUN) && beat_hs && !tlast_q;
    assign next_is_last = (beat_cnt == beats_q - ONE_BEAT);

    // State register.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. A zero-length start goes straight to DONE so that
    // the caller still sees a completion pulse.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (ctrl_start) begin
                    state_n = (ctrl_length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (beat_hs && tlast_q) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Registered output stage. It loads a beat only when the stage is empty
    // (a new start) or the current beat handshakes, so the stream outputs
    // stay stable while tready is low.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            base_q      <= '0;
            beat_cnt    <= '0;
            beats_q     <= '0;
            last_keep_q <= '0;
        end else if (load_first) begin
            tvalid_q    <= 1'b1;
            tdata_q     <= lane_pattern(ctrl_seed);
            tlast_q     <= (beats_in == ONE_BEAT);
            tkeep_q     <= (beats_in == ONE_BEAT) ? keep_in : '1;
            base_q      <= ctrl_seed + LANE_STEP;
            beat_cnt    <= ONE_BEAT;
            beats_q     <= beats_in;
            last_keep_q <= keep_in;
        end else if (load_next) begin
            tdata_q  <= lane_pattern(base_q);
            tlast_q  <= next_is_last;
            tkeep_q  <= next_is_last ? last_keep_q : '1;
            base_q   <= base_q + LANE_STEP;
            beat_cnt <= beat_cnt + ONE_BEAT;
        end else if (beat_hs) begin
            // The final beat was accepted, so the output stage is now empty.
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            beat_cnt <= '0;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;

    assign ctrl_busy = (state != S_IDLE);
    assign ctrl_done = (state == S_DONE);
    assign dbg_state = state;
endmodule

// File: tb/tb_sysarray_example_axis_gen.sv
module tb_sysarray_example_axis_gen;
    localparam int DW = 512;
    localparam int AW = 32;
    localparam int LW = 32;
    localparam int KW = DW / 8;
    localparam int EW = 1 + KW + DW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ctrl_start = 1'b0;
    logic [LW-1:0]  ctrl_length = '0;
    logic [AW-1:0]  ctrl_seed = '0;
    logic           ctrl_busy;
    logic           ctrl_done;
    logic [1:0]     dbg_state;

    sysarray_example_axis_gen_if #(.DATA_WIDTH(DW)) m_axis();

    sysarray_example_axis_gen #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_ADDER_BIT_WIDTH(AW),
        .C_LENGTH_WIDTH(LW)
    ) dut (
        .m_axis_aclk(clk),
        .m_axis_areset(rst),
        .ctrl_start(ctrl_start),
        .ctrl_length(ctrl_length),
        .ctrl_seed(ctrl_seed),
        .ctrl_busy(ctrl_busy),
        .ctrl_done(ctrl_done),
        .dbg_state(dbg_state),
        .m_axis(m_axis)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int done_count = 0;
    bit ready_rand = 1'b0;
    logic [EW-1:0] exp_q[$];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int i);
        return m_axis.tdata[i*AW +: AW];
    endfunction

    // Reference beat: lane i of beat k = seed + 16k + i. On the final beat
    // tkeep holds the low (len mod 64) bits, or all bits when the remainder is 0.
    function automatic logic [EW-1:0] beat_exp(input logic [31:0] len, input logic [31:0] seed,
                                               input longint k, input longint nb);
        logic [DW-1:0] d;
        logic [KW-1:0] keep;
        logic [KW:0]   tmp;
        longint        r;
        logic [31:0]   v;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            v = seed + 32'(k * 16 + i);
            d[i*AW +: AW] = v;
        end
        r = longint'(len) % 64;
        if (k == nb - 1 && r != 0) begin
            tmp  = (65'd1 << r) - 65'd1;
            keep = tmp[KW-1:0];
        end else begin
            keep = '1;
        end
        return {(k == nb - 1), keep, d};
    endfunction

    task automatic push_pkt(input logic [31:0] len, input logic [31:0] seed);
        longint nb;
        nb = (longint'(len) + 63) / 64;
        for (longint k = 0; k < nb; k++) exp_q.push_back(beat_exp(len, seed, k, nb));
    endtask

    // Pulses start for one cycle. On return the bench is in cycle N+1, where
    // N is the cycle the start was accepted in. Length and seed are then
    // scrambled so that late changes would corrupt the packet if the design
    // were sensitive to them.
    task automatic start_pkt(input logic [31:0] len, input logic [31:0] seed);
        @(posedge clk);
        #1;
        ctrl_start  = 1'b1;
        ctrl_length = len;
        ctrl_seed   = seed;
        @(posedge clk);
        #1;
        ctrl_start  = 1'b0;
        ctrl_length = $urandom;
        ctrl_seed   = $urandom;
    endtask

    // ---------------- tready driver ----------------
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          prev_stall;
        logic [EW-1:0] prev_beat;
        logic [EW-1:0] cur;
        logic [EW-1:0] exp;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                cur = {m_axis.tlast, m_axis.tkeep, m_axis.tdata};
                if (ctrl_done) done_count++;
                if (prev_stall) begin
                    checks++;
                    if (!m_axis.tvalid || cur !== prev_beat) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b beat=%0h required valid=1 beat=%0h",
                                 m_axis.tvalid, cur, prev_beat);
                    end
                end
                if (m_axis.tvalid && m_axis.tready) begin
                    hs_count++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %0h required none", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        if (cur !== exp) begin
                            errors++;
                            $display("FAIL beat: got %0h required %0h", cur, exp);
                        end
                    end
                end
                prev_stall = m_axis.tvalid && !m_axis.tready;
                prev_beat  = cur;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  hs0;
        int  dc0;
        bit  got_done;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tvalid", m_axis.tvalid, 1'b0);
        check("rst_tlast", m_axis.tlast, 1'b0);
        check("rst_tdata_zero", m_axis.tdata == '0, 1'b1);
        check("rst_tkeep", m_axis.tkeep, 64'h0);
        check("rst_busy", ctrl_busy, 1'b0);
        check("rst_done", ctrl_done, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Test 1: len=256, seed=0, tready=1 -> 4 beats, done in N+5
        push_pkt(256, 0);
        start_pkt(256, 0);
        for (int k = 0; k < 4; k++) begin
            check("t1_tvalid", m_axis.tvalid, 1'b1);
            check("t1_tlast", m_axis.tlast, (k == 3));
            check("t1_busy", ctrl_busy, 1'b1);
            check("t1_done_low", ctrl_done, 1'b0);
            if (k == 0) check("t1_b0_lane15", lane(15), 32'd15);
            if (k == 3) check("t1_b3_lane0", lane(0), 32'd48);
            if (k == 3) check("t1_b3_lane15", lane(15), 32'd63);
            next_cycle();
        end
        check("t1_done", ctrl_done, 1'b1);
        check("t1_done_tvalid", m_axis.tvalid, 1'b0);
        check("t1_done_state", dbg_state, 2'd2);
        next_cycle();
        check("t1_idle_busy", ctrl_busy, 1'b0);
        check("t1_idle_done", ctrl_done, 1'b0);

        // Test 2: len=100, seed=7 -> 2 beats, last keeps 36 bytes
        push_pkt(100, 7);
        start_pkt(100, 7);
        check("t2_b0_lane0", lane(0), 32'd7);
        check("t2_b0_keep", m_axis.tkeep, 64'hFFFFFFFFFFFFFFFF);
        check("t2_b0_last", m_axis.tlast, 1'b0);
        next_cycle();
        check("t2_b1_keep", m_axis.tkeep, 64'h0000000FFFFFFFFF);
        check("t2_b1_last", m_axis.tlast, 1'b1);
        check("t2_b1_lane0", lane(0), 32'd23);
        next_cycle();
        check("t2_done", ctrl_done, 1'b1);
        next_cycle();

        // Test 5: seed wrap
        push_pkt(64, 32'hFFFFFFF8);
        start_pkt(64, 32'hFFFFFFF8);
        check("t5_lane7", lane(7), 32'hFFFFFFFF);
        check("t5_lane8", lane(8), 32'h00000000);
        check("t5_lane15", lane(15), 32'h00000007);
        check("t5_last", m_axis.tlast, 1'b1);
        next_cycle();
        check("t5_done", ctrl_done, 1'b1);
        next_cycle();

        // Test 4: len=0 -> no beats, one-cycle done and busy
        hs0 = hs_count;
        dc0 = done_count;
        start_pkt(0, 5);
        check("t4_done", ctrl_done, 1'b1);
        check("t4_busy", ctrl_busy, 1'b1);
        check("t4_tvalid", m_axis.tvalid, 1'b0);
        next_cycle();
        check("t4_done_after", ctrl_done, 1'b0);
        check("t4_busy_after", ctrl_busy, 1'b0);
        check("t4_tvalid_after", m_axis.tvalid, 1'b0);
        next_cycle();
        check("t4_no_beats", hs_count - hs0, 0);
        check("t4_one_done", done_count - dc0, 1);

        // Test 3: len=4096, random tready, ignored start pulses while running
        ready_rand = 1'b1;
        push_pkt(4096, 32'hABCD0000);
        hs0 = hs_count;
        dc0 = done_count;
        start_pkt(4096, 32'hABCD0000);
        got_done = 1'b0;
        for (int i = 0; i < 1000 && !got_done; i++) begin
            if (ctrl_done) begin
                got_done = 1'b1;
            end else begin
                ctrl_start  = (i % 17 == 5);
                ctrl_length = 64;
                next_cycle();
            end
        end
        ctrl_start = 1'b0;
        check("t3_done_seen", got_done, 1'b1);
        check("t3_handshakes", hs_count - hs0, 64);
        check("t3_queue_empty", exp_q.size(), 0);
        ready_rand = 1'b0;
        next_cycle();
        next_cycle();
        check("t3_one_done", done_count - dc0, 1);
        check("t3_idle", ctrl_busy, 1'b0);

        // Test 6: asynchronous reset during beat 2 of 4
        dc0 = done_count;
        push_pkt(256, 32'h100);
        start_pkt(256, 32'h100);
        next_cycle();
        next_cycle();
        check("t6_b2_lane0", lane(0), 32'h120);
        rst = 1'b1;
        #1;
        check("t6_rst_tvalid", m_axis.tvalid, 1'b0);
        check("t6_rst_busy", ctrl_busy, 1'b0);
        check("t6_rst_tdata_zero", m_axis.tdata == '0, 1'b1);
        check("t6_rst_tlast", m_axis.tlast, 1'b0);
        next_cycle();
        next_cycle();
        check("t6_two_consumed", exp_q.size(), 2);
        exp_q.delete();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        check("t6_no_done", done_count - dc0, 0);
        check("t6_idle", dbg_state, 2'd0);
        push_pkt(64, 1);
        start_pkt(64, 1);
        check("t6_new_tvalid", m_axis.tvalid, 1'b1);
        check("t6_new_lane0", lane(0), 32'd1);
        check("t6_new_last", m_axis.tlast, 1'b1);
        next_cycle();
        check("t6_new_done", ctrl_done, 1'b1);
        next_cycle();
        next_cycle();

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sysarray_example_axis_gen.md
# sysarray_example_axis_gen

AXI4-Stream packet generator that produces the input stream consumed by the systolic-array example adder datapath. On a start pulse it emits one packet of a programmed byte length. Each 32-bit lane carries a deterministic counting pattern derived from a seed. It obeys full AXIS master handshake rules under arbitrary backpressure and signals completion with a one-cycle done pulse. It is used as the stimulus source in kernel loopback and as the data source for on-chip self-test.

## Interface
Parameters:
- C_AXIS_TDATA_WIDTH, 512, stream data width in bits; multiple of C_ADDER_BIT_WIDTH and of 8
- C_ADDER_BIT_WIDTH, 32, lane width of the counting pattern
- C_LENGTH_WIDTH, 32, width of the byte-length control field

Ports:
- m_axis_aclk  in  1  sole clock; all logic on its rising edge
- m_axis_areset  in  1  asynchronous, active-high reset
- ctrl_start  in  1  single-cycle start request; sampled only in IDLE
- ctrl_length  in  C_LENGTH_WIDTH  packet length in bytes; latched on accepted start
- ctrl_seed  in  C_ADDER_BIT_WIDTH  pattern seed; latched on accepted start
- ctrl_busy  out  1  high whenever state is not IDLE
- ctrl_done  out  1  one-cycle pulse after the packet completes
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  beat data
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  byte enables
- m_axis_tlast  out  1  final beat of the packet

## Operation
- Derived constants: BPB = C_AXIS_TDATA_WIDTH/8 bytes per beat; L = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH lanes.
- Beat count B = ceil(ctrl_length / BPB). Compute it without overflow for ctrl_length up to 2^C_LENGTH_WIDTH−1.
- States:
  - IDLE: start with length>0 → RUN; start with length=0 → DONE.
  - RUN: after the handshake of beat B−1 → DONE.
  - DONE: lasts one cycle, then → IDLE.
- ctrl_start is ignored in RUN and DONE. There is no queuing.
- Beat k (0-based), lane i: tdata[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] = seed + k*L + i, modulo 2^C_ADDER_BIT_WIDTH. Wrap silently.
- tkeep:
  - All ones on every beat except the last.
  - On the last beat, the low R bits are set, where R = ctrl_length mod BPB. If R=0, all bits are set.
- tlast is high on beat B−1 only.
- Outputs come from a registered output stage. A new beat loads when tvalid=0 or (tvalid & tready).
- AXIS rule: once tvalid=1, tvalid, tdata, tkeep and tlast hold stable until tready=1. tvalid never depends combinationally on tready.
- Reset:
  - All state clears asynchronously: state IDLE, beat counter 0.
  - Outputs reset to 0: tvalid, tlast, tdata, tkeep, busy, done.
  - A reset mid-packet abandons the packet. No tlast is emitted, and no done pulse follows reset.

## Timing
- Let start be accepted at the edge ending cycle N.
- Beat 0 appears with tvalid=1 in cycle N+1. busy=1 from cycle N+1.
- With tready held high, beat k is presented in cycle N+1+k, giving a throughput of one beat per cycle.
- The last beat handshakes in cycle N+B. In cycle N+B+1, done=1 and tvalid=0. In cycle N+B+2, the state is IDLE, busy=0, and a new start is accepted.
- Length=0: no tvalid; done=1 in cycle N+1.
- Stall cycles (tready=0 while tvalid=1) each delay all subsequent events by exactly one cycle.
- ctrl_length and ctrl_seed changes after acceptance have no effect on the current packet.

## Test plan
- len=256, seed=0, tready=1 → 4 beats in cycles N+1..N+4. Beat 0 lanes = 0..15; beat 3 lanes = 48..63. tkeep all ones. tlast only on beat 3. done in N+5.
- len=100, seed=7 → 2 beats. Beat 1 tkeep = 0x0000000FFFFFFFFF (36 bytes), tlast=1. Beat 1 lane 0 = 23.
- len=4096 with pseudo-random tready (50%) → exactly 64 handshakes. tdata, tkeep and tlast stay stable on every stalled cycle. A scoreboard matches the pattern. One done pulse.
- len=0 → tvalid never asserted; done=1 in cycle N+1 only; busy high for exactly one cycle.
- seed=0xFFFFFFF8, len=64 → beat 0 lane 7 = 0xFFFFFFFF, lane 8 = 0x00000000, lane 15 = 0x00000007.
- Start pulses during RUN are ignored (beat count unchanged). Assert areset asynchronously during beat 2 of 4 → tvalid, busy and tdata drop to 0 immediately, with no done. After release, start with len=64, seed=1 → single beat, lane 0 = 1, tlast=1.
